// File: rtl/sd_arb_pkg.sv
// Shared types and constants for the two-requester SD block arbiter.
package sd_arb_pkg;

    // Width of a sector address on every port.
    localparam int LBA_W = 32;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        XFER  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Latched operation of a pending request.
    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_t;

    // A read strobe takes precedence when a requester pulses both lines.
    function automatic op_t op_of(input logic rd);
        return rd ? OP_RD : OP_WR;
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-input round-robin picker: on a tie the requester that did not win the
// previous tie is chosen; a lone requester always wins.
module rr_pick2 (
    input  logic [1:0] pending,
    input  logic       last,
    output logic [1:0] winner,
    output logic       valid
);

    // Pick the one-hot winner from the pending set and the tie pointer.
    always_comb begin
        // NOTE: every output gets a default before the case so no path can
        // leave it unassigned and infer a latch.
        winner = 2'b00;
        valid  = |pending;
        case (pending)
            2'b01:   winner = 2'b01;
            2'b10:   winner = 2'b10;
            2'b11:   winner = last ? 2'b01 : 2'b10;
            default: winner = 2'b00;
        endcase
    end

endmodule

// File: rtl/sd_req_arbiter.sv
// Arbitrates block read/write requests from two clients onto one hps_io SD
// port. Each client has a single pending slot; the FSM issues the request,
// waits for sd_ack, follows the transfer and signals completion.
module sd_req_arbiter
    import sd_arb_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 5000000
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic [1:0]       rd_stb,
    input  logic [1:0]       wr_stb,
    input  logic [LBA_W-1:0] lba0,
    input  logic [LBA_W-1:0] lba1,
    output logic [LBA_W-1:0] sd_lba,
    output logic             sd_rd,
    output logic             sd_wr,
    input  logic             sd_ack,
    output logic [1:0]       grant,
    output logic [1:0]       done,
    output logic             err,
    output logic             busy
);

    // Last value of the ack-wait counter before the request is abandoned.
    localparam logic [31:0] TMO_LAST = 32'(ACK_TIMEOUT - 1);

    state_t           state;
    state_t           state_nxt;

    logic [1:0]       stb_any;
    logic [LBA_W-1:0] lba_in [2];

    logic [1:0]       pend_q;
    op_t              op_q   [2];
    logic [LBA_W-1:0] lba_q  [2];

    // Index of the requester that won the most recent tie.
    logic             last_q;
    logic [31:0]      tmo_cnt;

    logic [1:0]       win;
    logic             win_vld;
    logic             win_idx;

    // FSM transition strobes decoded in the next-state logic.
    logic             do_issue;
    logic             do_ack;
    logic             do_timeout;
    logic             do_xfer_end;

    assign stb_any   = rd_stb | wr_stb;
    assign lba_in[0] = lba0;
    assign lba_in[1] = lba1;
    assign win_idx   = win[1];
    assign busy      = (state != IDLE);

    rr_pick2 u_rr_pick2 (
        .pending (pend_q),
        .last    (last_q),
        .winner  (win),
        .valid   (win_vld)
    );

    // State register.
    always_ff @(posedge clk_sys) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value regardless of block ordering.
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and transition strobes.
    always_comb begin
        state_nxt   = state;
        do_issue    = 1'b0;
        do_ack      = 1'b0;
        do_timeout  = 1'b0;
        do_xfer_end = 1'b0;
        case (state)
            IDLE: begin
                // sd_ack is deliberately not looked at here.
                if (win_vld) begin
                    state_nxt = ISSUE;
                    do_issue  = 1'b1;
                end
            end
            ISSUE: begin
                // An ack on the last counted cycle still wins over the timeout.
                if (sd_ack) begin
                    state_nxt = XFER;
                    do_ack    = 1'b1;
                end else if (tmo_cnt == TMO_LAST) begin
                    state_nxt  = IDLE;
                    do_timeout = 1'b1;
                end
            end
            XFER: begin
                if (!sd_ack) begin
                    state_nxt   = DONE;
                    do_xfer_end = 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Per-requester pending slots: the first strobe is captured, repeats are
    // dropped until the slot is granted and freed.
    always_ff @(posedge clk_sys) begin
        // NOTE: the latched addresses are cleared on reset along with the
        // pending bits so a stale address can never reach sd_lba.
        if (reset) begin
            pend_q   <= 2'b00;
            op_q[0]  <= OP_RD;
            op_q[1]  <= OP_RD;
            lba_q[0] <= '0;
            lba_q[1] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (do_issue && win[i]) begin
                    pend_q[i] <= 1'b0;
                end else if (stb_any[i] && !pend_q[i]) begin
                    pend_q[i] <= 1'b1;
                    op_q[i]   <= op_of(rd_stb[i]);
                    lba_q[i]  <= lba_in[i];
                end
            end
        end
    end

    // SD port drive, grant, completion pulses, tie pointer and ack timeout.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            sd_lba  <= '0;
            sd_rd   <= 1'b0;
            sd_wr   <= 1'b0;
            grant   <= 2'b00;
            done    <= 2'b00;
            err     <= 1'b0;
            last_q  <= 1'b1;
            tmo_cnt <= '0;
        end else begin
            done <= 2'b00;
            err  <= 1'b0;

            if (state == ISSUE) begin
                tmo_cnt <= tmo_cnt + 32'd1;
            end

            if (do_issue) begin
                grant   <= win;
                sd_lba  <= lba_q[win_idx];
                sd_rd   <= (op_q[win_idx] == OP_RD);
                sd_wr   <= (op_q[win_idx] == OP_WR);
                tmo_cnt <= '0;
                // The pointer only moves when both requesters competed.
                if (pend_q == 2'b11) begin
                    last_q <= win_idx;
                end
            end

            if (do_ack) begin
                sd_rd <= 1'b0;
                sd_wr <= 1'b0;
            end

            if (do_timeout) begin
                sd_rd <= 1'b0;
                sd_wr <= 1'b0;
                done  <= grant;
                err   <= 1'b1;
                grant <= 2'b00;
            end

            if (do_xfer_end) begin
                done <= grant;
            end

            if (state == DONE) begin
                grant <= 2'b00;
            end
        end
    end

endmodule

// File: tb/tb_sd_req_arbiter.sv
// Scoreboard bench for sd_req_arbiter: stimulus pushes the expected SD-port
// events, an hps_io model answers requests, and a monitor compares events.
module tb_sd_req_arbiter;
    import sd_arb_pkg::*;

    localparam int unsigned TMO = 16;

    typedef enum logic [1:0] {EV_ISSUE, EV_DROP, EV_DONE} ev_kind_t;

    typedef struct {
        ev_kind_t    kind;
        int          req;
        bit          is_wr;
        logic [31:0] lba;
        bit          err;
        int          cyc;
    } ev_t;

    typedef struct {
        int d;
        int h;
        bit never;
    } host_t;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic [1:0]  rd_stb, wr_stb;
    logic [31:0] lba0, lba1;
    logic [31:0] sd_lba;
    logic        sd_rd, sd_wr, sd_ack;
    logic [1:0]  grant, done;
    logic        err, busy;

    int    cyc = 0;
    int    n_vec = 0;
    int    n_err = 0;
    int    done_cnt [2];
    int    next_tie;
    bit    mon_en = 1'b0;
    bit    prev_rdwr = 1'b0;
    bit    rdwr_now;
    bit    prev_h = 1'b0;
    host_t hp;
    ev_t   exp_q [$];
    host_t host_q [$];

    sd_req_arbiter #(.ACK_TIMEOUT(TMO)) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .rd_stb  (rd_stb),
        .wr_stb  (wr_stb),
        .lba0    (lba0),
        .lba1    (lba1),
        .sd_lba  (sd_lba),
        .sd_rd   (sd_rd),
        .sd_wr   (sd_wr),
        .sd_ack  (sd_ack),
        .grant   (grant),
        .done    (done),
        .err     (err),
        .busy    (busy)
    );

    always #5 clk_sys = ~clk_sys;
    always @(posedge clk_sys) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got 0x%0h, required 0x%0h", name, cyc, act, exp);
        end
    endtask

    // hps_io model: ack d cycles after a request appears, hold it h cycles.
    initial begin
        sd_ack = 1'b0;
        forever begin
            @(negedge clk_sys);
            if ((sd_rd | sd_wr) && !prev_h) begin
                if (host_q.size() == 0) begin
                    hp.d = 0; hp.h = 1; hp.never = 1'b0;
                end else begin
                    hp = host_q.pop_front();
                end
                if (!hp.never) begin
                    repeat (hp.d) @(negedge clk_sys);
                    sd_ack = 1'b1;
                    repeat (hp.h) @(negedge clk_sys);
                    sd_ack = 1'b0;
                end
            end
            prev_h = sd_rd | sd_wr;
        end
    end

    task automatic mon_event(input ev_kind_t k);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_event @cyc %0d: got %s, required none", cyc, k.name());
            return;
        end
        e = exp_q.pop_front();
        check("ev_kind", k, e.kind);
        check("ev_cycle", cyc, e.cyc);
        check("ev_sd_lba", sd_lba, e.lba);
        case (k)
            EV_ISSUE: begin
                check("issue_grant", grant, 2'b01 << e.req);
                check("issue_rd_wr", {sd_rd, sd_wr}, e.is_wr ? 2'b01 : 2'b10);
            end
            EV_DONE: begin
                check("done_req", done, 2'b01 << e.req);
                check("done_err", err, e.err);
            end
            default: ;
        endcase
    endtask

    // Monitor: turns output edges into events and checks port invariants.
    always @(negedge clk_sys) begin
        if (mon_en) begin
            rdwr_now = sd_rd | sd_wr;
            check("rd_wr_exclusive", sd_rd & sd_wr, 1'b0);
            check("grant_onehot0", $countones(grant) <= 1, 1'b1);
            check("busy_vs_grant", busy, grant != 2'b00);
            check("err_without_done", err && (done == 2'b00), 1'b0);
            if (rdwr_now && !prev_rdwr) mon_event(EV_ISSUE);
            if (!rdwr_now && prev_rdwr) mon_event(EV_DROP);
            if (done != 2'b00) begin
                mon_event(EV_DONE);
                if (done[0]) done_cnt[0]++;
                if (done[1]) done_cnt[1]++;
            end
            prev_rdwr = rdwr_now;
        end
    end

    task automatic push_ev(input ev_kind_t k, input int req, input bit is_wr,
                           input logic [31:0] lba, input bit e_err, input int t);
        ev_t e;
        e.kind = k; e.req = req; e.is_wr = is_wr; e.lba = lba; e.err = e_err; e.cyc = t;
        exp_q.push_back(e);
    endtask

    // A normal transfer issued at cycle t: drop after the ack, done after ack falls.
    task automatic expect_xfer(input int req, input bit is_wr, input logic [31:0] lba,
                               input int t, input int d, input int h, output int td);
        host_t p;
        p.d = d; p.h = h; p.never = 1'b0;
        host_q.push_back(p);
        push_ev(EV_ISSUE, req, is_wr, lba, 1'b0, t);
        push_ev(EV_DROP,  req, is_wr, lba, 1'b0, t + d + 1);
        push_ev(EV_DONE,  req, is_wr, lba, 1'b0, t + d + h + 1);
        td = t + d + h + 1;
    endtask

    task automatic drive_stb(input logic [1:0] rd, input logic [1:0] wr,
                             input logic [31:0] l0, input logic [31:0] l1);
        rd_stb = rd; wr_stb = wr; lba0 = l0; lba1 = l1;
        @(negedge clk_sys);
        rd_stb = 2'b00; wr_stb = 2'b00; lba0 = $urandom; lba1 = $urandom;
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk_sys);
    endtask

    task automatic drain(input int budget);
        int b;
        b = budget;
        while (exp_q.size() != 0 && b > 0) begin
            @(negedge clk_sys);
            b--;
        end
        check("events_outstanding", exp_q.size(), 0);
        exp_q.delete();
        repeat (2) @(negedge clk_sys);
    endtask

    // sel: 1 = read strobe, 2 = write strobe, 3 = both (read).
    task automatic run_single(input int r, input int sel, input logic [31:0] lba,
                              input int d, input int h);
        int s, td;
        logic [1:0] rv, wv;
        s = cyc;
        expect_xfer(r, sel == 2, lba, s + 2, d, h, td);
        rv = 2'b00; wv = 2'b00;
        rv[r] = sel[0]; wv[r] = sel[1];
        drive_stb(rv, wv, (r == 0) ? lba : $urandom, (r == 1) ? lba : $urandom);
        drain(td - s + 20);
    endtask

    task automatic run_tie(input int sel0, input int sel1, input logic [31:0] l0,
                           input logic [31:0] l1, input int d0, input int h0,
                           input int d1, input int h1);
        int s, td1, td2, first, second;
        int sel [2];
        int d [2];
        int h [2];
        logic [31:0] l [2];
        sel[0] = sel0; sel[1] = sel1; d[0] = d0; d[1] = d1;
        h[0] = h0; h[1] = h1; l[0] = l0; l[1] = l1;
        first  = next_tie;
        second = 1 - first;
        next_tie = 1 - first;
        s = cyc;
        expect_xfer(first, sel[first] == 2, l[first], s + 2, d[first], h[first], td1);
        expect_xfer(second, sel[second] == 2, l[second], td1 + 2, d[second], h[second], td2);
        drive_stb({sel[1][0], sel[0][0]}, {sel[1][1], sel[0][1]}, l0, l1);
        drain(td2 - s + 20);
    endtask

    task automatic run_timeout(input logic [31:0] lba);
        int s, t;
        host_t p;
        s = cyc;
        t = s + 2;
        p.d = 0; p.h = 0; p.never = 1'b1;
        host_q.push_back(p);
        push_ev(EV_ISSUE, 0, 1'b0, lba, 1'b0, t);
        push_ev(EV_DROP,  0, 1'b0, lba, 1'b0, t + TMO);
        push_ev(EV_DONE,  0, 1'b0, lba, 1'b1, t + TMO);
        drive_stb(2'b01, 2'b00, lba, $urandom);
        wait_cyc(t + TMO + 1);
        check("busy_after_timeout", busy, 1'b0);
        drain(10);
    endtask

    // Requester 1 re-strobes during its own transfer, then repeats while pending.
    task automatic run_restrobe(input logic [31:0] la, input int d, input int d2, input int h2);
        int s, t, td1, td2, base;
        base = done_cnt[1];
        s = cyc;
        t = s + 2;
        expect_xfer(1, 1'b1, la, t, d, 4, td1);
        expect_xfer(1, 1'b1, 32'h20, td1 + 2, d2, h2, td2);
        drive_stb(2'b00, 2'b10, $urandom, la);
        wait_cyc(t + d + 1);
        drive_stb(2'b00, 2'b10, $urandom, 32'h20);
        drive_stb(2'b00, 2'b10, $urandom, 32'h99);
        drain(td2 - s + 20);
        check("restrobe_done1_count", done_cnt[1] - base, 2);
    endtask

    // Tie won by requester 0, reset during its XFER while ack is still high.
    task automatic run_reset_mid();
        int s, t;
        host_t p;
        next_tie = 1;
        s = cyc;
        t = s + 2;
        p.d = 2; p.h = 10; p.never = 1'b0;
        host_q.push_back(p);
        push_ev(EV_ISSUE, 0, 1'b0, 32'h0000_0abc, 1'b0, t);
        push_ev(EV_DROP,  0, 1'b0, 32'h0000_0abc, 1'b0, t + 3);
        drive_stb(2'b01, 2'b10, 32'h0000_0abc, 32'h0000_0def);
        wait_cyc(t + 5);
        reset = 1'b1;
        @(negedge clk_sys);
        reset = 1'b0;
        next_tie = 0;
        check("rst_mid_sd_rd", sd_rd, 1'b0);
        check("rst_mid_sd_wr", sd_wr, 1'b0);
        check("rst_mid_grant", grant, 2'b00);
        check("rst_mid_done", done, 2'b00);
        check("rst_mid_err", err, 1'b0);
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_sd_lba", sd_lba, 32'h0);
        check("rst_mid_ack_still_high", sd_ack, 1'b1);
        wait_cyc(t + 30);
        drain(5);
    endtask

    initial begin
        done_cnt[0] = 0;
        done_cnt[1] = 0;
        next_tie = 0;
        reset = 1'b1;
        rd_stb = 2'b00; wr_stb = 2'b00; lba0 = '0; lba1 = '0;
        repeat (2) @(negedge clk_sys);
        rd_stb = 2'b11; lba0 = 32'h1234; lba1 = 32'h5678;
        @(negedge clk_sys);
        rd_stb = 2'b00;
        check("rst_sd_rd", sd_rd, 1'b0);
        check("rst_sd_wr", sd_wr, 1'b0);
        check("rst_grant", grant, 2'b00);
        check("rst_done", done, 2'b00);
        check("rst_err", err, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_sd_lba", sd_lba, 32'h0);
        reset = 1'b0;
        mon_en = 1'b1;
        repeat (5) @(negedge clk_sys);

        run_single(0, 1, 32'h0000_0010, 3, 4);
        run_single(1, 2, 32'hdead_beef, 15, 2);
        run_single(0, 3, 32'h0000_7777, 14, 1);
        run_single(1, 1, 32'hffff_ffff, 0, 1);

        run_tie(1, 2, 32'd5, 32'd9, 2, 3, 1, 2);
        run_tie(2, 1, $urandom, $urandom, 1, 2, 3, 1);

        run_timeout(32'h0000_0042);
        run_restrobe(32'h0000_0100, $urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(1, 5));

        for (int i = 0; i < 16; i++) begin
            run_single($urandom_range(0, 1), $urandom_range(1, 3), $urandom,
                       $urandom_range(0, 15), $urandom_range(1, 6));
        end
        for (int i = 0; i < 6; i++) begin
            run_tie($urandom_range(1, 3), $urandom_range(1, 3), $urandom, $urandom,
                    $urandom_range(0, 8), $urandom_range(1, 5),
                    $urandom_range(0, 8), $urandom_range(1, 5));
        end

        if (next_tie != 0) begin
            run_tie(1, 1, $urandom, $urandom, 1, 1, 1, 1);
        end
        run_reset_mid();
        run_tie($urandom_range(1, 3), $urandom_range(1, 3), $urandom, $urandom, 2, 2, 2, 2);

        repeat (30) @(negedge clk_sys);
        check("final_busy", busy, 1'b0);
        check("final_events_outstanding", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sd_req_arbiter.md
SD_REQ_ARBITER -- requirements
Module: sd_req_arbiter

Interface
REQ-001 Parameter ACK_TIMEOUT, default 5000000, is the number of clk_sys cycles to wait for sd_ack before abandoning a request.
REQ-002 clk_sys  in  1  system clock; all logic runs on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 rd_stb  in  2  per-requester one-cycle block-read strobe; index 0 and index 1 are the two requesters.
REQ-005 wr_stb  in  2  per-requester one-cycle block-write strobe.
REQ-006 lba0 / lba1  in  32 each  sector address, sampled in the same cycle as that requester's strobe.
REQ-007 sd_lba  out  32  sector address for hps_io.
REQ-008 sd_rd / sd_wr  out  1 each  request lines to hps_io.
REQ-009 sd_ack  in  1  hps_io acknowledge; high for the whole buffer transfer.
REQ-010 grant  out  2  one-hot owner of the SD port; 0 when idle.
REQ-011 done  out  2  one-cycle completion pulse per requester.
REQ-012 err  out  1  one-cycle pulse, coincident with done, when a request timed out.
REQ-013 busy  out  1  high in every state except IDLE.

Function
REQ-014 Each strobe shall set that requester's pending bit and latch its op and lba (read if rd_stb, write if wr_stb; read wins when both are high).
REQ-015 A strobe while that requester's pending bit is already set shall be ignored; the first op and lba are kept.
REQ-016 A strobe from the currently granted requester shall set a new pending entry; it shall not disturb the active transfer.
REQ-017 States: IDLE, ISSUE, XFER, DONE.
REQ-018 IDLE, any pending -> ISSUE at the next edge.
  - In that edge: grant is set, sd_lba is loaded, sd_rd or sd_wr is asserted, and the winner's pending bit is cleared.
  - Latency from strobe to sd_rd/sd_wr is 2 cycles.
REQ-019 Arbitration is round-robin: if both are pending, grant the requester not granted last; after reset, requester 0 wins the first tie.
REQ-020 ISSUE: sd_rd/sd_wr stay asserted until sd_ack is sampled high; then, at that edge, deassert them and go to XFER.
REQ-021 ISSUE: a 32-bit timeout counter starts at 0 on entry and increments each cycle.
  - When it equals ACK_TIMEOUT-1 with sd_ack low: drop sd_rd/sd_wr, pulse done[grant] and err, and go to IDLE.
REQ-022 sd_ack sampled high and the counter at its limit in the same cycle: ack wins, and no err is raised.
REQ-023 XFER: there is no timeout; stay until sd_ack is sampled low, then go to DONE.
REQ-024 DONE: lasts 1 cycle.
  - done[grant] is high during it.
  - grant clears and the FSM returns to IDLE at the next edge.
REQ-025 From the sd_ack falling sample, done[grant] is high exactly 1 cycle later.
REQ-026 sd_lba shall hold its value from ISSUE through DONE.
REQ-027 A pending entry raised during a transfer shall be serviced from the IDLE cycle that follows DONE.
  - IDLE always lasts at least 1 cycle between transfers.
REQ-028 sd_rd and sd_wr shall never both be high, and neither shall be high outside ISSUE.
REQ-029 sd_ack high while in IDLE is ignored.

Reset
REQ-030 reset shall force the following at the next edge, overriding all strobes:
  - state IDLE;
  - pending bits 0, latched lba 0, sd_lba 0;
  - sd_rd, sd_wr, grant, done, err all 0; busy 0;
  - timeout counter 0;
  - round-robin pointer so that requester 0 wins the next tie.
REQ-031 reset mid-transfer shall abandon the transfer silently: no done or err pulse, even if sd_ack is still high.

Structure
REQ-032 Shared package sd_arb_pkg holds:
  - the state enum (IDLE, ISSUE, XFER, DONE);
  - the op type (OP_RD, OP_WR);
  - LBA_W = 32.
REQ-033 The two-input round-robin pick is the only sub-module: rr_pick2.
  - Inputs: pending[1:0], last.
  - Outputs: one-hot winner and valid.
  - Purely combinational.
REQ-034 All remaining logic is flat in sd_req_arbiter.

Verification
REQ-035 rd_stb[0]=1 with lba0=0x00000010; the model acks 3 cycles after sd_rd and holds ack 4 cycles.
  - sd_rd rises 2 cycles after the strobe, with sd_lba=0x10 and grant=01.
  - sd_rd falls the cycle after the ack is sampled.
  - done[0] pulses 1 cycle after ack falls; err=0.
REQ-036 rd_stb[0] and wr_stb[1] in the same cycle, lbas 5 and 9.
  - Requester 0 is served first with a read at lba 5, then requester 1 with a write at lba 9.
  - A second tie afterwards is won by requester 1.
REQ-037 ACK_TIMEOUT=16 and the model never acks.
  - sd_rd stays high for 16 cycles, then drops.
  - done[0] and err pulse together; busy returns to 0.
REQ-038 wr_stb[1] during its own XFER with lba1=0x20, plus a repeated strobe while pending.
  - The first done is followed by a second transfer at lba 0x20 (the repeated strobe's lba is ignored).
  - Exactly 2 done[1] pulses.
REQ-039 reset asserted while in XFER with sd_ack still high.
  - The next cycle shows all outputs 0 and no done pulse, even when ack later falls.
